// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch/sequencing stage in front of the LEGv8 register-file/ALU/RAM datapath.
// Keeps the program counter, the instruction register and the registered
// V/C/N/Z flags, and alternates between a FETCH phase (latch the instruction
// word) and an EXECUTE phase (update PC, optionally latch ALU status).
//
// Ports:
//   clk          system clock, state updates on the rising edge
//   rst          asynchronous active-high reset
//   instr_in     instruction word read from instruction memory at PC
//   PC_in        absolute/register branch target from the datapath
//   Status       live ALU flags {V,C,N,Z}
//   SL           latch Status into flags during EXECUTE
//   PS           PC mode: 00 hold, 01 increment, 10 load PC_in, 11 relative branch
//   offset       sign-extended word offset used by PS=11
//   cond_en      PS=11 branch is conditional on cond when set
//   cond         LEGv8 condition code
//   halt         freezes all state while high
//   PC           current program counter
//   IR           instruction register
//   flags        registered {V,C,N,Z}
//   ir_valid     high in EXECUTE
//   branch_taken high in EXECUTE when PS=11 and the branch is taken
module pc_sequencer #(
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr_in,
    input  logic [DATA_WIDTH-1:0] PC_in,
    input  logic [3:0]            Status,
    input  logic                  SL,
    input  logic [1:0]            PS,
    input  logic [DATA_WIDTH-1:0] offset,
    input  logic                  cond_en,
    input  logic [3:0]            cond,
    input  logic                  halt,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [31:0]           IR,
    output logic [3:0]            flags,
    output logic                  ir_valid,
    output logic                  branch_taken
);

    typedef enum logic {
        FETCH   = 1'b0,
        EXECUTE = 1'b1
    } phase_t;

    phase_t                phase_q, phase_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           ir_q, ir_d;
    logic [3:0]            flags_q, flags_d;

    logic                  flagV, flagC, flagN, flagZ;
    logic                  condTrue;
    logic                  taken;
    logic [DATA_WIDTH-1:0] offsetShifted;
    logic [DATA_WIDTH-1:0] pcStep;
    logic [DATA_WIDTH-1:0] pcSeq;
    logic [DATA_WIDTH-1:0] pcRel;

    assign flagV = flags_q[3];
    assign flagC = flags_q[2];
    assign flagN = flags_q[1];
    assign flagZ = flags_q[0];

    // Conditions are judged on the registered flags only, so an SL in the
    // same EXECUTE cannot influence the branch it accompanies.
    always_comb begin
        condTrue = 1'b1;
        case (cond)
            4'b0000: condTrue = flagZ;
            4'b0001: condTrue = ~flagZ;
            4'b0010: condTrue = flagC;
            4'b0011: condTrue = ~flagC;
            4'b0100: condTrue = flagN;
            4'b0101: condTrue = ~flagN;
            4'b0110: condTrue = flagV;
            4'b0111: condTrue = ~flagV;
            4'b1000: condTrue = flagC & ~flagZ;
            4'b1001: condTrue = ~(flagC & ~flagZ);
            4'b1010: condTrue = (flagN == flagV);
            4'b1011: condTrue = (flagN != flagV);
            4'b1100: condTrue = ~flagZ & (flagN == flagV);
            4'b1101: condTrue = ~(~flagZ & (flagN == flagV));
            default: condTrue = 1'b1;
        endcase
    end

    assign taken = ~cond_en | condTrue;

    // Word offset becomes a byte offset; high bits shifted out are dropped
    // and all sums wrap modulo 2^DATA_WIDTH.
    assign offsetShifted = offset << 2;
    assign pcStep        = DATA_WIDTH'(PC_STEP);
    assign pcSeq         = pc_q + pcStep;
    assign pcRel         = pc_q + offsetShifted;

    // Next-state logic: FETCH only captures the instruction, EXECUTE moves
    // the PC and optionally latches status; halt leaves everything as is.
    always_comb begin
        phase_d = phase_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        if (!halt) begin
            if (phase_q == FETCH) begin
                ir_d    = instr_in;
                phase_d = EXECUTE;
            end else begin
                phase_d = FETCH;
                case (PS)
                    2'b00:   pc_d = pc_q;
                    2'b01:   pc_d = pcSeq;
                    2'b10:   pc_d = PC_in;
                    default: pc_d = taken ? pcRel : pcSeq;
                endcase
                if (SL) begin
                    flags_d = Status;
                end
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            phase_q <= phase_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    assign PC           = pc_q;
    assign IR           = ir_q;
    assign flags        = flags_q;
    assign ir_valid     = (phase_q == EXECUTE);
    assign branch_taken = (phase_q == EXECUTE) && (PS == 2'b11) && taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: walks through sequential fetch,
// conditional branches, flag latching order, PC wrap, halt and async reset.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] instr_in;
    logic [63:0] PC_in;
    logic [3:0]  Status;
    logic        SL;
    logic [1:0]  PS;
    logic [63:0] offset;
    logic        cond_en;
    logic [3:0]  cond;
    logic        halt;
    logic [63:0] PC;
    logic [31:0] IR;
    logic [3:0]  flags;
    logic        ir_valid;
    logic        branch_taken;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    pc_sequencer #(
        .DATA_WIDTH (64),
        .RESET_PC   (64'h0),
        .PC_STEP    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_in     (instr_in),
        .PC_in        (PC_in),
        .Status       (Status),
        .SL           (SL),
        .PS           (PS),
        .offset       (offset),
        .cond_en      (cond_en),
        .cond         (cond),
        .halt         (halt),
        .PC           (PC),
        .IR           (IR),
        .flags        (flags),
        .ir_valid     (ir_valid),
        .branch_taken (branch_taken)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the EXECUTE-relevant inputs for the coming edge.
    task automatic applyStimulus(input logic [1:0] ps, input logic sl,
                                 input logic [3:0] status, input logic [63:0] pcIn,
                                 input logic [63:0] off, input logic condEn,
                                 input logic [3:0] cnd, input logic [31:0] instr);
        PS       = ps;
        SL       = sl;
        Status   = status;
        PC_in    = pcIn;
        offset   = off;
        cond_en  = condEn;
        cond     = cnd;
        instr_in = instr;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] condExp;

    initial begin
        rst  = 1'b1;
        halt = 1'b0;
        applyStimulus(2'b11, 1'b1, 4'hF, 64'h0, 64'h0, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("reset_pc", PC, 64'h0);
        checkOutput("reset_ir", {32'h0, IR}, 64'h0);
        checkOutput("reset_flags", {60'h0, flags}, 64'h0);
        checkOutput("reset_irvalid", {63'h0, ir_valid}, 64'h0);
        checkOutput("reset_branch", {63'h0, branch_taken}, 64'h0);
        tick();
        checkOutput("reset_held_pc", PC, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch/execute with PS=01
        applyStimulus(2'b01, 1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 4'h0, 32'hA1A1_0001);
        tick();
        checkOutput("seq_c1_ir", {32'h0, IR}, 64'hA1A1_0001);
        checkOutput("seq_c1_pc", PC, 64'h0);
        checkOutput("seq_c1_valid", {63'h0, ir_valid}, 64'h1);
        instr_in = 32'hA1A1_0002;
        tick();
        checkOutput("seq_c2_pc", PC, 64'h4);
        checkOutput("seq_c2_ir", {32'h0, IR}, 64'hA1A1_0001);
        checkOutput("seq_c2_valid", {63'h0, ir_valid}, 64'h0);
        tick();
        checkOutput("seq_c3_ir", {32'h0, IR}, 64'hA1A1_0002);
        checkOutput("seq_c3_pc", PC, 64'h4);
        instr_in = 32'hA1A1_0003;
        tick();
        checkOutput("seq_c4_pc", PC, 64'h8);
        tick();
        checkOutput("seq_c5_ir", {32'h0, IR}, 64'hA1A1_0003);
        tick();
        checkOutput("seq_c6_pc", PC, 64'hC);

        // Load PC=0x100 and latch Z=1
        tick();
        applyStimulus(2'b10, 1'b1, 4'b0001, 64'h100, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        checkOutput("load100_pc", PC, 64'h100);
        checkOutput("load100_flags", {60'h0, flags}, 64'h1);

        // BEQ with offset -2 taken: 0x100 - 8 = 0xF8
        applyStimulus(2'b00, 1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 4'h0, 32'hB0B0_0000);
        tick();
        applyStimulus(2'b11, 1'b0, 4'h0, 64'h0, -64'sd2, 1'b1, 4'b0000, 32'h0);
        #1;
        checkOutput("beq_branch", {63'h0, branch_taken}, 64'h1);
        tick();
        checkOutput("beq_pc", PC, 64'hF8);
        checkOutput("beq_branch_fetch", {63'h0, branch_taken}, 64'h0);

        // Back to 0x100, BNE not taken -> 0x104
        applyStimulus(2'b00, 1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        applyStimulus(2'b10, 1'b0, 4'h0, 64'h100, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        tick();
        applyStimulus(2'b11, 1'b0, 4'h0, 64'h0, -64'sd2, 1'b1, 4'b0001, 32'h0);
        #1;
        checkOutput("bne_branch", {63'h0, branch_taken}, 64'h0);
        tick();
        checkOutput("bne_pc", PC, 64'h104);

        // Same-cycle SL and BEQ: old Z=1 decides, new flags land after
        applyStimulus(2'b00, 1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        applyStimulus(2'b10, 1'b0, 4'h0, 64'h40, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        tick();
        applyStimulus(2'b11, 1'b1, 4'b0000, 64'h0, 64'h1, 1'b1, 4'b0000, 32'h0);
        #1;
        checkOutput("slbr_branch", {63'h0, branch_taken}, 64'h1);
        tick();
        checkOutput("slbr_pc", PC, 64'h44);
        checkOutput("slbr_flags", {60'h0, flags}, 64'h0);
        applyStimulus(2'b00, 1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        applyStimulus(2'b11, 1'b0, 4'h0, 64'h0, 64'h1, 1'b1, 4'b0000, 32'h0);
        #1;
        checkOutput("beq_newz_branch", {63'h0, branch_taken}, 64'h0);
        tick();
        checkOutput("beq_newz_pc", PC, 64'h48);

        // Unconditional relative branch, offset 4 words
        applyStimulus(2'b00, 1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        applyStimulus(2'b11, 1'b0, 4'h0, 64'h0, 64'h4, 1'b0, 4'b0000, 32'h0);
        tick();
        checkOutput("uncond_pc", PC, 64'h58);

        // Latch V=1,C=0,N=1,Z=0 with PS=00 hold
        applyStimulus(2'b00, 1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        applyStimulus(2'b00, 1'b1, 4'b1010, 64'h0, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        checkOutput("hold_pc", PC, 64'h58);
        checkOutput("flags_1010", {60'h0, flags}, 64'hA);

        // Sweep every condition code while parked in EXECUTE under halt
        applyStimulus(2'b00, 1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        halt    = 1'b1;
        PS      = 2'b11;
        cond_en = 1'b1;
        offset  = 64'h10;
        condEx_init: condExp = 16'hD65A;
        for (int i = 0; i < 16; i++) begin
            cond = 4'(i);
            #1;
            checkOutput($sformatf("cond_%0d", i), {63'h0, branch_taken}, {63'h0, condExp[i]});
        end
        @(negedge clk);
        halt = 1'b0;
        PS   = 2'b00;
        tick();
        checkOutput("cond_sweep_pc", PC, 64'h58);

        // Wrap at the top of the address space, then register load
        tick();
        applyStimulus(2'b10, 1'b0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        applyStimulus(2'b00, 1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        PS = 2'b01;
        tick();
        checkOutput("wrap_pc", PC, 64'h0);
        PS = 2'b00;
        tick();
        applyStimulus(2'b10, 1'b0, 4'h0, 64'h1234, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        checkOutput("load1234_pc", PC, 64'h1234);

        // Halt for three edges while in EXECUTE
        applyStimulus(2'b00, 1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 4'h0, 32'hC0DE_0001);
        tick();
        applyStimulus(2'b01, 1'b1, 4'b0101, 64'h0, 64'h0, 1'b0, 4'h0, 32'hDEAD_BEEF);
        halt = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("halt_pc", PC, 64'h1234);
        checkOutput("halt_ir", {32'h0, IR}, 64'hC0DE_0001);
        checkOutput("halt_flags", {60'h0, flags}, 64'hA);
        checkOutput("halt_valid", {63'h0, ir_valid}, 64'h1);
        @(negedge clk);
        halt = 1'b0;
        tick();
        checkOutput("resume_pc", PC, 64'h1238);
        checkOutput("resume_valid", {63'h0, ir_valid}, 64'h0);
        checkOutput("resume_flags", {60'h0, flags}, 64'h5);

        // Async reset mid-EXECUTE at PC=0x80
        applyStimulus(2'b00, 1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        applyStimulus(2'b10, 1'b0, 4'h0, 64'h80, 64'h0, 1'b0, 4'h0, 32'h0);
        tick();
        applyStimulus(2'b11, 1'b0, 4'h0, 64'h0, 64'h0, 1'b0, 4'h0, 32'hFACE_0001);
        tick();
        checkOutput("pre_rst_pc", PC, 64'h80);
        checkOutput("pre_rst_valid", {63'h0, ir_valid}, 64'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_pc", PC, 64'h0);
        checkOutput("async_rst_ir", {32'h0, IR}, 64'h0);
        checkOutput("async_rst_valid", {63'h0, ir_valid}, 64'h0);
        checkOutput("async_rst_flags", {60'h0, flags}, 64'h0);
        checkOutput("async_rst_branch", {63'h0, branch_taken}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_ir", {32'h0, IR}, 64'hFACE_0001);
        checkOutput("post_rst_pc", PC, 64'h0);
        checkOutput("post_rst_valid", {63'h0, ir_valid}, 64'h1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
